// File: rtl/rv_ifu_pkg.sv
// Shared definitions for the instruction fetch unit and the decode stage that consumes it.
package rv_ifu_pkg;

  localparam logic [31:0] ResetPcDefault = 32'h8000_0000;
  localparam logic [31:0] EbreakInst     = 32'h0010_0073;
  localparam logic [6:0]  OpcSystem      = 7'b1110011;

  localparam logic [2:0] StReq  = 3'd0;
  localparam logic [2:0] StWait = 3'd1;
  localparam logic [2:0] StHold = 3'd2;
  localparam logic [2:0] StErr  = 3'd3;
  localparam logic [2:0] StHalt = 3'd4;

  function automatic logic is_ebreak(input logic [31:0] insn);
    return (insn[6:0] == OpcSystem) && (insn[31:7] == EbreakInst[31:7]);
  endfunction

endpackage

// File: rtl/rv_ifu_if.sv
// Fetch-side bus: instruction memory request/response plus the instruction stream to decode.
interface rv_ifu_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_rsp_valid;
  logic [WIDTH-1:0] imem_rsp_data;
  logic             imem_rsp_err;
  logic             inst_valid;
  logic             inst_ready;
  logic [WIDTH-1:0] inst;
  logic [WIDTH-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, inst_ready
  );

endinterface

// File: rtl/rv_ifu_pc.sv
// Program counter with next-PC selection: redirect load beats sequential advance, else hold.
module rv_ifu_pc
  import rv_ifu_pkg::*;
#(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(ResetPcDefault)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_pc_i,
  input  logic             advance_i,
  output logic [WIDTH-1:0] pc_o
);

  logic [WIDTH-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (advance_i) begin
      pc_d = pc_q + WIDTH'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/rv_ifu.sv
// Single-outstanding instruction fetch unit feeding decode over valid/ready.
// Optional RV_IFU_EBREAK_HALT_EN: stop fetching after an ebreak is handed to decode.
module rv_ifu
  import rv_ifu_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(ResetPcDefault)
) (
  input  logic             clk,
  input  logic             rst,
  rv_ifu_if.master         bus_io,
  input  logic             redirect_valid_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             fetch_err_o,
  output logic             halt_o
);

  logic [2:0]       state_d, state_q;
  logic             drop_d, drop_q;
  logic             fetch_err_d, fetch_err_q;
  logic [WIDTH-1:0] inst_d, inst_q;
  logic [WIDTH-1:0] inst_pc_d, inst_pc_q;
  logic [WIDTH-1:0] pc;
  logic             req_fire, rsp_seen, xfer, pending, misaligned;
`ifdef RV_IFU_EBREAK_HALT_EN
  logic             halt_d, halt_q;
`endif

  assign req_fire   = (state_q == StReq) && bus_io.imem_req_ready;
  assign rsp_seen   = bus_io.imem_rsp_valid && ((state_q == StWait) || drop_q);
  assign xfer       = (state_q == StHold) && bus_io.inst_ready;
  assign misaligned = redirect_pc_i[1:0] != 2'b00;
  // A request is still owed a response after this edge unless it lands right now.
  assign pending    = req_fire || (((state_q == StWait) || drop_q) && !rsp_seen);

  rv_ifu_pc #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load_i    (redirect_valid_i),
    .load_pc_i (redirect_pc_i),
    .advance_i (xfer),
    .pc_o      (pc)
  );

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    fetch_err_d = fetch_err_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
`ifdef RV_IFU_EBREAK_HALT_EN
    halt_d      = halt_q;
`endif
    if (redirect_valid_i) begin
      drop_d      = pending;
      fetch_err_d = misaligned;
`ifdef RV_IFU_EBREAK_HALT_EN
      halt_d      = 1'b0;
`endif
      if (misaligned) begin
        state_d = StErr;
      end else if (pending) begin
        state_d = StWait;
      end else begin
        state_d = StReq;
      end
    end else begin
      case (state_q)
        StReq: begin
          if (req_fire) state_d = StWait;
        end
        StWait: begin
          if (rsp_seen) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = StReq;
            end else if (bus_io.imem_rsp_err) begin
              fetch_err_d = 1'b1;
              state_d     = StErr;
            end else begin
              inst_d    = bus_io.imem_rsp_data;
              inst_pc_d = pc;
              state_d   = StHold;
            end
          end
        end
        StHold: begin
          if (xfer) begin
            state_d = StReq;
`ifdef RV_IFU_EBREAK_HALT_EN
            if (is_ebreak(inst_q[31:0])) begin
              state_d = StHalt;
              halt_d  = 1'b1;
            end
`endif
          end
        end
        StErr: begin
          // Soak up a response orphaned by a misaligned redirect.
          if (rsp_seen) drop_d = 1'b0;
        end
`ifdef RV_IFU_EBREAK_HALT_EN
        StHalt: state_d = StHalt;
`endif
        default: state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StReq;
      drop_q      <= 1'b0;
      fetch_err_q <= 1'b0;
      inst_q      <= '0;
      inst_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      fetch_err_q <= fetch_err_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
    end
  end

`ifdef RV_IFU_EBREAK_HALT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end
  assign halt_o = halt_q;
`else
  assign halt_o = 1'b0;
`endif

  assign bus_io.imem_req_valid = (state_q == StReq);
  assign bus_io.imem_addr      = pc;
  assign bus_io.inst_valid     = (state_q == StHold);
  assign bus_io.inst           = inst_q;
  assign bus_io.inst_pc        = inst_pc_q;
  assign fetch_err_o           = fetch_err_q;

endmodule

// File: doc/rv_ifu.md
# rv_ifu

Instruction fetch unit: producer end of the instruction stream consumed by `rv_IDU`. It holds the PC, issues single-outstanding fetch requests to instruction memory and presents each fetched word with its PC to the decoder over a valid/ready handshake. It also accepts PC redirects from execute/branch logic.

## Interface
- `WIDTH`, 32: address and instruction width.
- `RESET_PC`, 32'h8000_0000: PC loaded on reset.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_addr`  out  WIDTH  fetch address (current PC).
- `imem_rsp_valid`  in  1  response valid (always accepted in WAIT).
- `imem_rsp_data`  in  WIDTH  fetched instruction.
- `imem_rsp_err`  in  1  access fault on this response.
- `inst_valid`  out  1  instruction available to decoder.
- `inst_ready`  in  1  decoder accepts instruction.
- `inst`  out  WIDTH  instruction word.
- `inst_pc`  out  WIDTH  PC of `inst`.
- `redirect_valid`  in  1  load new PC.
- `redirect_pc`  in  WIDTH  new PC.
- `fetch_err`  out  1  sticky fault flag.
- `halt`  out  1  fetch stopped on ebreak.

## Operation
- States: REQ, WAIT, HOLD, ERR, HALT. Reset: state=REQ, pc=RESET_PC, drop=0, inst=0, inst_pc=0, fetch_err=0, halt=0; inst_valid=0.
- REQ: `imem_req_valid`=1, `imem_addr`=pc. On valid&ready -> WAIT.
- WAIT: on `imem_rsp_valid`: if drop, clear drop, -> REQ (data discarded); else if `imem_rsp_err` -> ERR, fetch_err=1; else latch data into `inst`, pc into `inst_pc` -> HOLD.
- HOLD: `inst_valid`=1, `inst`/`inst_pc` stable until transfer. On inst_valid&inst_ready: pc<=pc+4 (mod 2^WIDTH, wraps) -> REQ (or HALT, see Configuration).
- ERR: no requests, inst_valid=0; exit only by redirect. fetch_err clears on redirect.
- Redirect (highest priority, any state): pc<=redirect_pc, next state REQ, with exceptions:
  - WAIT, or REQ with request accepted same cycle: -> WAIT with drop=1 (in-flight response discarded). Redirect in WAIT while response arrives same cycle: response discarded, -> REQ.
  - HOLD without handshake: held instruction dropped, inst_valid=0 next cycle.
  - HOLD with handshake same cycle: transfer counts, next pc=redirect_pc (not pc+4).
  - REQ unaccepted: `imem_addr` changes to redirect_pc next cycle (only allowed address change while pending).
  - ERR/HALT: clear fetch_err/halt, -> REQ.
- redirect_pc[1:0]!=0: no fetch; -> ERR, fetch_err=1.

## Timing
- At most one request outstanding.
- Reset release -> `imem_req_valid`=1 in first cycle with addr=RESET_PC.
- Zero-wait memory, always-ready decoder: request cycle, response cycle, HOLD cycle -> one instruction per 3 cycles.
- `inst_valid` rises the cycle after response capture. Redirect effect visible on `imem_addr` the cycle after redirect_valid.
- Async reset mid-operation: all outputs to reset values immediately; memory shares `rst`, so no stale response.

## Configuration
- `RV_IFU_EBREAK_HALT_EN` defined: when HOLD transfer completes with `inst`==32'h0010_0073, -> HALT: `halt`=1, no requests, inst_valid=0 until redirect.
- Undefined: ebreak fetched as ordinary instruction; `halt` tied 0; HALT state absent.

## Structure
- Shared header: state encodings, `RESET_PC` default, EBREAK encoding, SYSTEM opcode 7'b1110011 (also used by decode).
- Sub-module `rv_ifu_pc`: PC register with next-PC mux (reset / redirect / pc+4 / hold).

## Test plan
- Reset release, zero-wait memory returns 0x00000013 three times -> imem_addr 0x80000000, 0x80000004, 0x80000008; inst_pc matches; inst_valid 1 every 3rd cycle.
- inst_ready held 0 for 5 cycles in HOLD -> inst/inst_pc stable, no new request; release -> next addr +4.
- Redirect to 0x80001000 while in WAIT; old response arrives 2 cycles later -> response discarded, next request addr 0x80001000, no inst_valid for old word.
- Response with imem_rsp_err=1 -> fetch_err=1, requests stop; redirect to 0x80000000 -> fetch_err=0, fetch resumes; redirect to 0x80000002 -> fetch_err=1, no request.
- With `RV_IFU_EBREAK_HALT_EN`: fetch 0x00100073, accept -> halt=1, no further requests; without macro -> next request at pc+4, halt=0.
- rst asserted during HOLD -> inst_valid=0 immediately, after release first addr 0x80000000.
